// File: rtl/dht11_sensor_model.sv
// DHT11 sensor-side responder: detects a host start pulse and answers with the preamble and a 40-bit frame.
// Define DHT11_MODEL_CS_INJECT_EN to add cs_corrupt, which flips checksum bit 0 of the latched frame.
//
// state      | meaning
// IDLE       | bus released, waiting for the host to pull low
// HOST_LOW   | timing the host start pulse
// RESP_DELAY | released, short wait after host release
// RESP_LOW   | response preamble, low phase
// RESP_HIGH  | response preamble, high phase
// BIT_LOW    | low lead-in of the current bit
// BIT_HIGH   | released, length encodes the current bit
// END_LOW    | trailing low after the last bit
module dht11_sensor_model #(
    parameter int unsigned START_MIN_TICKS  = 1000,
    parameter int unsigned RESP_DELAY_TICKS = 3,
    parameter int unsigned RESP_LOW_TICKS   = 8,
    parameter int unsigned RESP_HIGH_TICKS  = 8,
    parameter int unsigned BIT_LOW_TICKS    = 5,
    parameter int unsigned ZERO_HIGH_TICKS  = 3,
    parameter int unsigned ONE_HIGH_TICKS   = 7,
    parameter int unsigned END_LOW_TICKS    = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tick,
    input  logic [31:0] sensor_data,
`ifdef DHT11_MODEL_CS_INJECT_EN
    input  logic        cs_corrupt,
`endif
    inout  wire         dht_io,
    output logic        busy,
    output logic        done,
    output logic [7:0]  frame_cnt
);

    typedef enum logic [2:0] {
        S_IDLE, S_HOST_LOW, S_RESP_DELAY, S_RESP_LOW,
        S_RESP_HIGH, S_BIT_LOW, S_BIT_HIGH, S_END_LOW
    } state_t;

    localparam logic [10:0] START_MIN  = START_MIN_TICKS[10:0];
    localparam logic [10:0] RESP_DELAY = RESP_DELAY_TICKS[10:0];
    localparam logic [10:0] RESP_LOW   = RESP_LOW_TICKS[10:0];
    localparam logic [10:0] RESP_HIGH  = RESP_HIGH_TICKS[10:0];
    localparam logic [10:0] BIT_LOW    = BIT_LOW_TICKS[10:0];
    localparam logic [10:0] ZERO_HIGH  = ZERO_HIGH_TICKS[10:0];
    localparam logic [10:0] ONE_HIGH   = ONE_HIGH_TICKS[10:0];
    localparam logic [10:0] END_LOW    = END_LOW_TICKS[10:0];

    state_t      state_q, state_d;
    logic [10:0] cnt_q, cnt_d;
    logic [39:0] frame_q, frame_d;
    logic [5:0]  bit_idx_q, bit_idx_d;
    logic        drive_low_q, drive_low_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [7:0]  frame_cnt_q, frame_cnt_d;
    logic        sync1_q, sync2_q;
    logic [7:0]  cs;
    logic [10:0] dur;

    // Open-drain: only ever pull low, the external pull-up supplies the high level.
    assign dht_io    = drive_low_q ? 1'b0 : 1'bz;
    assign busy      = busy_q;
    assign done      = done_q;
    assign frame_cnt = frame_cnt_q;

    always_comb begin
        cs = sensor_data[31:24] + sensor_data[23:16] + sensor_data[15:8] + sensor_data[7:0];
`ifdef DHT11_MODEL_CS_INJECT_EN
        cs = cs ^ {7'd0, cs_corrupt};
`endif
    end

    always_comb begin
        case (state_q)
            S_RESP_DELAY: dur = RESP_DELAY;
            S_RESP_LOW:   dur = RESP_LOW;
            S_RESP_HIGH:  dur = RESP_HIGH;
            S_BIT_LOW:    dur = BIT_LOW;
            S_BIT_HIGH:   dur = frame_q[39] ? ONE_HIGH : ZERO_HIGH;
            S_END_LOW:    dur = END_LOW;
            default:      dur = 11'd1;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        frame_d     = frame_q;
        bit_idx_d   = bit_idx_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        frame_cnt_d = frame_cnt_q;
        if (tick) begin
            case (state_q)
                S_IDLE: begin
                    if (!sync2_q) begin
                        state_d = S_HOST_LOW;
                        cnt_d   = 11'd1;
                    end
                end
                S_HOST_LOW: begin
                    if (!sync2_q) begin
                        if (cnt_q != 11'h7FF) cnt_d = cnt_q + 11'd1;
                    end else if (cnt_q >= START_MIN) begin
                        frame_d = {sensor_data, cs};
                        busy_d  = 1'b1;
                        state_d = S_RESP_DELAY;
                        cnt_d   = '0;
                    end else begin
                        state_d = S_IDLE;
                        cnt_d   = '0;
                    end
                end
                default: begin
                    if (cnt_q == dur - 11'd1) begin
                        cnt_d = '0;
                        case (state_q)
                            S_RESP_DELAY: state_d = S_RESP_LOW;
                            S_RESP_LOW:   state_d = S_RESP_HIGH;
                            S_RESP_HIGH: begin
                                state_d   = S_BIT_LOW;
                                bit_idx_d = '0;
                            end
                            S_BIT_LOW:    state_d = S_BIT_HIGH;
                            S_BIT_HIGH: begin
                                frame_d   = {frame_q[38:0], 1'b0};
                                bit_idx_d = bit_idx_q + 6'd1;
                                state_d   = (bit_idx_q == 6'd39) ? S_END_LOW : S_BIT_LOW;
                            end
                            default: begin
                                state_d     = S_IDLE;
                                done_d      = 1'b1;
                                busy_d      = 1'b0;
                                frame_cnt_d = frame_cnt_q + 8'd1;
                            end
                        endcase
                    end else if (cnt_q != 11'h7FF) begin
                        cnt_d = cnt_q + 11'd1;
                    end
                end
            endcase
        end
        drive_low_d = (state_d == S_RESP_LOW) || (state_d == S_BIT_LOW) || (state_d == S_END_LOW);
    end

    // Synchronizer resets high so a reset release never looks like a start pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= dht_io;
            sync2_q <= sync1_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            frame_q     <= '0;
            bit_idx_q   <= '0;
            drive_low_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            frame_q     <= frame_d;
            bit_idx_q   <= bit_idx_d;
            drive_low_q <= drive_low_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

endmodule
